// File: rtl/manchester_frame_ctrl.sv
// manchester_frame_ctrl: hunts a sync word in the decoded bit stream, reads a length byte, streams the payload on AXIS.
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset
//   dec_bits[1:0], dec_num     decoded bits (bit0 older) and how many are valid (3 counts as 0)
//   dec_clear                  one-cycle pulse on abort, flushes the decoder
//   m_axis_*                   payload bytes out, tlast on the final byte of a frame
//   frame_active               high while reading length or payload
//   frame_err                  one-cycle pulse on any abort
//   frame_cnt                  frames whose last byte entered the output buffer
module manchester_frame_ctrl #(
    parameter logic [15:0] SYNC_WORD    = 16'hA5C3,
    parameter int          MAX_LEN      = 64,
    parameter int          IDLE_TIMEOUT = 32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [1:0]  dec_bits,
    input  logic [1:0]  dec_num,
    output logic        dec_clear,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        frame_active,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, ABORT} state_t;
    state_t        state, st;
    logic [15:0]   window, win;
    logic [7:0]    shreg, sh, byte_left, bl;
    logic [2:0]    bit_cnt, bc;
    logic [IW-1:0] idle_cnt, idl;
    logic [8:0]    e0, e1, pdat;
    logic [1:0]    cnt, vld;
    logic          push, done, stop, pop, b;
    assign vld           = {dec_num == 2'd2, dec_num == 2'd1 || dec_num == 2'd2};
    assign m_axis_tvalid = cnt != 2'd0;
    assign m_axis_tdata  = e0[7:0];
    assign m_axis_tlast  = e0[8];
    assign pop           = m_axis_tvalid & m_axis_tready;
    // Both bits of a cycle are walked in order so an event on bit0 steers where bit1 lands.
    always_comb begin
        st   = state;
        win  = window;
        sh   = shreg;
        bc   = bit_cnt;
        bl   = byte_left;
        idl  = '0;
        push = 1'b0;
        pdat = '0;
        done = 1'b0;
        stop = 1'b0;
        b    = 1'b0;
        if (state == ABORT) begin
            st  = HUNT;
            win = '0;
            sh  = '0;
            bc  = '0;
            bl  = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (vld[i] && !stop) begin
                    b = dec_bits[i];
                    case (st)
                        HUNT: begin
                            win = {win[14:0], b};
                            // window restarts empty so a new hunt needs 16 fresh bits
                            if (win == SYNC_WORD) begin
                                st  = LEN;
                                win = '0;
                                bc  = '0;
                            end
                        end
                        LEN: begin
                            sh = {sh[6:0], b};
                            bc = bc + 3'd1;
                            if (bc == 3'd0) begin
                                st   = (sh == 8'd0 || sh > 8'(MAX_LEN)) ? ABORT : PAYLOAD;
                                bl   = sh;
                                stop = st == ABORT;
                            end
                        end
                        PAYLOAD: begin
                            sh = {sh[6:0], b};
                            bc = bc + 3'd1;
                            if (bc == 3'd0) begin
                                push = 1'b1;
                                pdat = {bl == 8'd1, sh};
                                bl   = bl - 8'd1;
                                done = bl == 8'd0;
                                st   = done ? HUNT : PAYLOAD;
                                stop = done;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // a byte with nowhere to go kills the frame; queued bytes still drain
            if (push && cnt == 2'd2 && !pop) begin
                st   = ABORT;
                push = 1'b0;
                done = 1'b0;
            end
            if ((state == LEN || state == PAYLOAD) && !vld[0]) begin
                idl = idle_cnt + 1'b1;
                if (idl == IW'(IDLE_TIMEOUT)) st = ABORT;
            end
        end
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= HUNT;
            window       <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            byte_left    <= '0;
            idle_cnt     <= '0;
            e0           <= '0;
            e1           <= '0;
            cnt          <= '0;
            frame_cnt    <= '0;
            frame_err    <= 1'b0;
            dec_clear    <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            state        <= st;
            window       <= win;
            shreg        <= sh;
            bit_cnt      <= bc;
            byte_left    <= bl;
            idle_cnt     <= idl;
            frame_cnt    <= frame_cnt + {15'd0, done};
            frame_err    <= st == ABORT;
            dec_clear    <= st == ABORT;
            frame_active <= st == LEN || st == PAYLOAD;
            if (pop) e0 <= (cnt == 2'd2 || !push) ? e1 : pdat;
            else if (push && cnt == 2'd0) e0 <= pdat;
            if (push && (pop ? cnt == 2'd2 : cnt == 2'd1)) e1 <= pdat;
            cnt <= cnt + {1'b0, push && !pop} - {1'b0, pop && !push};
        end
    end
endmodule

// File: tb/tb_manchester_frame_ctrl.sv
// tb_manchester_frame_ctrl: directed and randomized frames checked against expected byte queues.
module tb_manchester_frame_ctrl;
    localparam logic [15:0] SYNC = 16'hA5C3;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [1:0]  dec_bits = '0;
    logic [1:0]  dec_num = '0;
    logic        dec_clear;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        frame_active;
    logic        frame_err;
    logic [15:0] frame_cnt;
    int          n_chk = 0;
    int          n_fail = 0;
    int          err_n = 0;
    int          clr_n = 0;
    int          stretch = 0;
    int          err0, clr0;
    logic        prev_err = 1'b0;
    logic        bq[$];
    logic [7:0]  pl[$];
    logic [8:0]  got[$];
    logic [8:0]  exp[$];
    logic [15:0] exp_fc = '0;
    manchester_frame_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .dec_bits(dec_bits), .dec_num(dec_num),
        .dec_clear(dec_clear), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .frame_active(frame_active), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );
    always #5 aclk = ~aclk;
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});
        if (frame_err) err_n++;
        if (dec_clear) clr_n++;
        if (frame_err && prev_err) stretch++;
        prev_err = frame_err;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic cyc(input logic [1:0] bits, input logic [1:0] num);
        dec_bits = bits;
        dec_num  = num;
        @(posedge aclk);
        #1;
    endtask
    task automatic idle(input int k);
        repeat (k) cyc(2'($urandom), 2'd0);
    endtask
    task automatic send(input int k, input int mode);
        int left;
        left = k;
        while (left > 0 && bq.size() > 0) begin
            int n;
            logic [1:0] r;
            logic b0, b1;
            r = 2'($urandom);
            n = mode == 1 ? 1 : mode == 2 ? 2 : (r == 2'd3 ? 0 : int'(r));
            if (n > left) n = left;
            if (n > bq.size()) n = bq.size();
            if (n == 0) cyc(2'($urandom), r);
            else if (n == 1) begin
                b0 = bq.pop_front();
                cyc({1'($urandom), b0}, 2'd1);
            end else begin
                b0 = bq.pop_front();
                b1 = bq.pop_front();
                cyc({b1, b0}, 2'd2);
            end
            left -= n;
        end
        dec_num = 2'd0;
    endtask
    task automatic put(input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) bq.push_back(v[i]);
    endtask
    task automatic mk(input logic [7:0] len, input bit ok);
        put(SYNC, 16);
        put({8'd0, len}, 8);
        foreach (pl[i]) begin
            put({8'd0, pl[i]}, 8);
            if (ok) exp.push_back({i == pl.size() - 1, pl[i]});
        end
        if (ok) exp_fc++;
    endtask
    task automatic drain();
        for (int c = 0; c < 300 && got.size() < exp.size(); c++) idle(1);
        idle(2);
    endtask
    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {23'd0, got[i]}, {23'd0, exp[i]});
        got.delete();
        exp.delete();
    endtask
    initial begin
        idle(3);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_active", frame_active, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_clear", dec_clear, 0);
        chk("rst_cnt", frame_cnt, 0);
        aresetn = 1'b1;
        idle(2);
        pl = '{8'h11, 8'h22, 8'h33};
        mk(8'd3, 1'b1);
        put(16'd0, 2);
        send(31, 1);
        chk("t1_pre_valid", m_axis_tvalid, 0);
        send(1, 1);
        chk("t1_lat_valid", m_axis_tvalid, 1);
        chk("t1_lat_data", m_axis_tdata, 8'h11);
        chk("t1_lat_last", m_axis_tlast, 0);
        send(100000, 1);
        drain();
        cmp_q("t1");
        chk("t1_cnt", frame_cnt, exp_fc);
        bq.push_back(1'b0);
        mk(8'd3, 1'b1);
        put(16'd0, 2);
        send(100000, 2);
        drain();
        cmp_q("t2");
        chk("t2_cnt", frame_cnt, exp_fc);
        err0 = err_n;
        clr0 = clr_n;
        pl.delete();
        mk(8'd0, 1'b0);
        put(16'd0, 2);
        send(100000, 1);
        idle(3);
        chk("t3_len0_err", err_n - err0, 1);
        chk("t3_len0_clr", clr_n - clr0, 1);
        mk(8'd65, 1'b0);
        put(16'd0, 2);
        send(100000, 2);
        idle(3);
        chk("t3_len65_err", err_n - err0, 2);
        chk("t3_len65_clr", clr_n - clr0, 2);
        cmp_q("t3");
        chk("t3_cnt", frame_cnt, exp_fc);
        err0 = err_n;
        m_axis_tready = 1'b0;
        pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        mk(8'd4, 1'b0);
        exp.push_back({1'b0, 8'hA1});
        exp.push_back({1'b0, 8'hB2});
        put(16'd0, 2);
        send(100000, 2);
        idle(2);
        chk("t4_err", err_n - err0, 1);
        chk("t4_valid_held", m_axis_tvalid, 1);
        chk("t4_active", frame_active, 0);
        m_axis_tready = 1'b1;
        drain();
        cmp_q("t4");
        chk("t4_cnt", frame_cnt, exp_fc);
        err0 = err_n;
        pl = '{8'h11, 8'h22, 8'h33};
        mk(8'd3, 1'b0);
        exp.push_back({1'b0, 8'h11});
        send(32, 1);
        idle(31);
        chk("t5_31_err", frame_err, 0);
        chk("t5_31_active", frame_active, 1);
        idle(1);
        chk("t5_32_err", frame_err, 1);
        chk("t5_32_clear", dec_clear, 1);
        chk("t5_32_active", frame_active, 0);
        idle(1);
        chk("t5_err_gone", frame_err, 0);
        bq.delete();
        drain();
        cmp_q("t5a");
        mk(8'd3, 1'b1);
        put(16'd0, 2);
        send(32, 1);
        idle(31);
        send(100000, 1);
        drain();
        cmp_q("t5b");
        chk("t5_err_total", err_n - err0, 1);
        chk("t5_cnt", frame_cnt, exp_fc);
        err0 = err_n;
        for (int f = 0; f < 6; f++) begin
            int len;
            len = f == 0 ? 1 : f == 1 ? 64 : int'($urandom_range(1, 64));
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            mk(8'(len), 1'b1);
            put(16'd0, 2);
            send(100000, 0);
            drain();
            cmp_q($sformatf("rnd%0d", f));
        end
        chk("rnd_cnt", frame_cnt, exp_fc);
        chk("rnd_err", err_n - err0, 0);
        chk("no_stretch", stretch, 0);
        err0 = err_n;
        m_axis_tready = 1'b0;
        pl = '{8'h5A, 8'h6B, 8'h7C};
        mk(8'd3, 1'b0);
        send(35, 1);
        chk("t6_pre_valid", m_axis_tvalid, 1);
        chk("t6_pre_active", frame_active, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("t6_valid", m_axis_tvalid, 0);
        chk("t6_active", frame_active, 0);
        chk("t6_clear", dec_clear, 0);
        chk("t6_cnt", frame_cnt, 0);
        bq.delete();
        got.delete();
        exp.delete();
        @(posedge aclk);
        #1 aresetn = 1'b1;
        m_axis_tready = 1'b1;
        exp_fc = '0;
        pl = '{8'h01, 8'hFE};
        mk(8'd2, 1'b1);
        put(16'd0, 2);
        send(100000, 2);
        drain();
        cmp_q("t6_next");
        chk("t6_next_cnt", frame_cnt, exp_fc);
        chk("t6_no_err", err_n - err0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
